// File: rtl/mul_acc_stage.sv
// Dot-product accumulation stage after the 32x32 tree multiplier: sums product beats
// until in_last, then holds the result behind a valid/ready handshake.
// Optional macro MUL_ACC_SATURATE_EN: clamp the accumulator on overflow instead of wrapping.
module mul_acc_stage #(
  parameter int ACC_W = 64,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_prod,
  input  logic             in_sign,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic              r_first;
  logic              r_grp_sign;

  logic              w_accept;
  logic              w_consume;
  logic [ACC_W:0]    w_sum;
  logic              w_ovf_signed;
  logic              w_ovf_unsigned;
  logic              w_ovf;
  logic [ACC_W-1:0]  w_acc_add;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_ACCUM;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_ACCUM;
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  assign w_accept  = in_valid && in_ready;
  assign w_consume = out_valid && out_ready;

  // One extra bit captures the unsigned carry; the signed rule looks only at the MSBs.
  assign w_sum          = {1'b0, r_acc} + {1'b0, in_prod};
  assign w_ovf_signed   = (r_acc[ACC_W-1] == in_prod[ACC_W-1]) &&
                          (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
  assign w_ovf_unsigned = w_sum[ACC_W];
  assign w_ovf          = r_grp_sign ? w_ovf_signed : w_ovf_unsigned;

  always_comb begin
    w_acc_add = w_sum[ACC_W-1:0];
`ifdef MUL_ACC_SATURATE_EN
    // Signed overflow direction follows the shared operand sign.
    if (w_ovf) begin
      if (!r_grp_sign)          w_acc_add = '1;
      else if (r_acc[ACC_W-1])  w_acc_add = {1'b1, {(ACC_W-1){1'b0}}};
      else                      w_acc_add = {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || w_consume) begin
      r_acc      <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_first    <= 1'b1;
      if (rst) r_grp_sign <= 1'b0;
    end else if (w_accept) begin
      if (r_first) begin
        r_acc      <= in_prod;
        r_grp_sign <= in_sign;
        r_ovf      <= 1'b0;
        r_first    <= 1'b0;
      end else begin
        r_acc <= w_acc_add;
        if (w_ovf) r_ovf <= 1'b1;
      end
      if (r_count != '1) r_count <= r_count + CNT_W'(1);
    end
  end

  assign out_acc   = r_acc;
  assign out_count = r_count;
  assign out_ovf   = r_ovf;
  assign busy      = (r_state == ST_FLUSH) || !r_first;

endmodule

// File: tb/tb_mul_acc_stage.sv
// Directed bench for mul_acc_stage (CNT_W=2 so count saturation is reachable);
// inputs driven and outputs sampled on the falling clock edge.
module tb_mul_acc_stage;

  localparam int ACC_W = 64;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] in_prod;
  logic             in_sign;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  mul_acc_stage #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_sign   (in_sign),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offers one beat for a single cycle; called and returns at a falling edge.
  task automatic beat(input logic [63:0] p, input logic s, input logic l);
    in_valid = 1'b1;
    in_prod  = p;
    in_sign  = s;
    in_last  = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [63:0] acc,
                              input logic [1:0] cnt, input logic ovf);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_acc"},   out_acc,        acc);
    check({tag, "_count"}, 64'(out_count), 64'(cnt));
    check({tag, "_ovf"},   64'(out_ovf),   64'(ovf));
  endtask

  logic [63:0] exp_sovf;
  logic [63:0] exp_uovf;

  initial begin
`ifdef MUL_ACC_SATURATE_EN
    exp_sovf = 64'h7FFF_FFFF_FFFF_FFFF;
    exp_uovf = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    exp_sovf = 64'h8000_0000_0000_0000;
    exp_uovf = 64'h0000_0000_0000_0001;
`endif
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_sign   = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_acc",       out_acc,        64'd0);
    check("rst_count",     64'(out_count), 64'd0);
    check("rst_ovf",       64'(out_ovf),   64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready),  64'd1);

    // in_last without in_valid must not start or end anything
    in_last = 1'b1;
    @(negedge clk);
    in_last = 1'b0;
    check("stray_last_valid", 64'(out_valid), 64'd0);
    check("stray_last_busy",  64'(busy),      64'd0);

    // Signed 5 + (-3) + 10; in_sign=0 on beat 2 must be ignored (unsigned would carry)
    beat(64'd5, 1'b1, 1'b0);
    check("t1_busy", 64'(busy), 64'd1);
    beat(64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
    beat(64'd10, 1'b0, 1'b1);
    check_result("t1", 64'd12, 2'd3, 1'b0);
    check("t1_in_ready_lo", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("t1_in_ready_hi", 64'(in_ready),  64'd1);
    check("t1_valid_drop",  64'(out_valid), 64'd0);
    check("t1_busy_drop",   64'(busy),      64'd0);

    // Signed positive overflow
    beat(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    beat(64'd1, 1'b1, 1'b1);
    check_result("t2", exp_sovf, 2'd2, 1'b1);
    @(negedge clk);

    // Unsigned carry; in_sign=1 on beat 2 ignored (signed rule would not flag)
    beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    beat(64'd2, 1'b1, 1'b1);
    check_result("t3", exp_uovf, 2'd2, 1'b1);
    @(negedge clk);
    beat(64'd7, 1'b0, 1'b1);
    check_result("t3b", 64'd7, 2'd1, 1'b0);
    @(negedge clk);

    // Backpressure: result held, offered beats refused
    out_ready = 1'b0;
    beat(64'd42, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_prod  = 64'd99;
      in_last  = 1'b1;
      check_result($sformatf("t4_hold%0d", i), 64'd42, 2'd1, 1'b0);
      check($sformatf("t4_in_ready%0d", i), 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_released_valid", 64'(out_valid), 64'd0);
    check("t4_released_ready", 64'(in_ready),  64'd1);
    beat(64'd8, 1'b0, 1'b1);
    check_result("t4_next", 64'd8, 2'd1, 1'b0);
    @(negedge clk);

    // Count saturation at CNT_W=2
    for (int i = 0; i < 6; i++) beat(64'd1, 1'b0, (i == 5));
    check_result("t5", 64'd6, 2'd3, 1'b0);
    @(negedge clk);

    // Reset mid-group discards the partial sum
    beat(64'd1, 1'b0, 1'b0);
    beat(64'd2, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_abort_valid", 64'(out_valid), 64'd0);
    check("t6_abort_busy",  64'(busy),      64'd0);
    check("t6_abort_acc",   out_acc,        64'd0);
    beat(64'd9, 1'b0, 1'b1);
    check_result("t6", 64'd9, 2'd1, 1'b0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_acc_stage.md
Name: mul_acc_stage

Overview:
- Downstream consumer of the 32x32 tree multiplier's 64-bit product.
- Accumulates a group of products (a dot product) into a 64-bit register, terminated by `in_last`.
- Presents the final sum with a valid/ready handshake, plus a beat count and a sticky overflow flag.
- Sits between the combinational multiplier output register and the result writeback path.

Parameters:
- ACC_W, 64, accumulator and product width in bits.
- CNT_W, 8, width of the beat counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  product beat available.
- in_ready  output  1  stage can accept a beat.
- in_prod  input  ACC_W  product from the multiplier.
- in_sign  input  1  1 = signed (two's-complement) group; sampled on the first beat of a group only.
- in_last  input  1  marks the final beat of the group.
- out_valid  output  1  group result available.
- out_ready  input  1  downstream accepts the result.
- out_acc  output  ACC_W  accumulated sum.
- out_count  output  CNT_W  number of beats in the group.
- out_ovf  output  1  sticky overflow for the group.
- busy  output  1  a group has started (at least one beat accepted) or a result is pending.

Behaviour:
- Reset: acc=0, count=0, ovf=0, first=1, grp_sign=0, state=ACCUM; outputs reset accordingly: out_valid=0, out_acc=0, out_count=0, out_ovf=0, busy=0.
- Reset mid-group or mid-FLUSH discards all state; no result is emitted.
- States: ACCUM, FLUSH.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Beat accepted when in_valid && in_ready.
- On an accepted beat:
  - If first=1: acc <= in_prod, grp_sign <= in_sign, ovf <= 0, first <= 0.
  - Else: acc <= acc + in_prod (ACC_W-bit wrap).
  - count <= count+1, saturating at all-ones (no wrap).
- Overflow rule (non-first beats):
  - Signed group: operands have equal MSBs and the sum MSB differs.
  - Unsigned group: carry out of bit ACC_W-1.
  - Overflow sets ovf; ovf stays set until the group is consumed.
- Beat with in_last=1:
  - The above update is applied, then state <= FLUSH.
  - Next cycle: out_valid=1 with out_acc/out_count/out_ovf showing the final values.
  - Latency from last beat to out_valid is 1 cycle.
- A single-beat group (first beat also has in_last) yields out_acc=in_prod, out_count=1, out_ovf=0.
- FLUSH:
  - in_ready=0; out_valid=1.
  - out_acc, out_count and out_ovf are held stable while out_ready=0.
  - On out_valid && out_ready: acc=0, count=0, ovf=0, first=1, state <= ACCUM.
  - in_ready rises the following cycle; there is no same-cycle bypass.
- in_sign on non-first beats is ignored.
- in_last is ignored unless the beat is accepted.
- in_valid while in FLUSH is not accepted; the upstream holds its beat.
- busy = (state==FLUSH) || (first==0).
- out_* contents during ACCUM reflect running state but carry no meaning while out_valid=0.

Optional Feature:
- Macro MUL_ACC_SATURATE_EN.
- Defined: on overflow, acc clamps instead of wrapping, and ovf still sets.
  - Signed positive overflow clamps to 0x7FFF_FFFF_FFFF_FFFF.
  - Signed negative overflow clamps to 0x8000_0000_0000_0000.
  - Unsigned overflow clamps to all-ones.
  - Later beats add to the clamped value under the same rules.
- Undefined: ACC_W-bit wrap-around as described in Behaviour.

Test Plan:
- Signed group 5, -3, 10 (last), out_ready=1 → out_valid 1 cycle after last beat; out_acc=12, out_count=3, out_ovf=0; in_ready low that cycle, high the next.
- Signed 0x7FFF_FFFF_FFFF_FFFF + 1 (last):
  - Without macro → out_acc=0x8000_0000_0000_0000, out_ovf=1.
  - With MUL_ACC_SATURATE_EN → out_acc=0x7FFF_FFFF_FFFF_FFFF, out_ovf=1.
- Unsigned 0xFFFF_FFFF_FFFF_FFFF + 2 (last) → without macro out_acc=1, out_ovf=1; the next group 7 (last) reports out_ovf=0.
- Backpressure: single beat 42 (last), out_ready=0 for 5 cycles → out_valid and out_acc=42 held stable, in_ready=0, beats offered with in_valid not accepted; out_ready=1 → handshake, then next group accepted.
- Count saturation with CNT_W=2: 6 beats of 1, last on the 6th → out_count=3, out_acc=6.
- rst asserted after 2 of 4 beats (1, 2), then new group 9 (last) → out_acc=9, out_count=1; no result emitted for the aborted group.
